// File: rtl/j1_io_pkg.sv
// Shared widths, status-page offsets and flag bit positions for the J1 I/O fabric.
package j1_io_pkg;

    localparam int DATA_W = 16;
    localparam int PAGE_W = 8;

    localparam logic [PAGE_W-1:0] STAT_UNMAP_CNT  = 8'h00;
    localparam logic [PAGE_W-1:0] STAT_LAST_UNMAP = 8'h01;
    localparam logic [PAGE_W-1:0] STAT_FLAGS      = 8'h02;
    localparam logic [PAGE_W-1:0] STAT_ACC_BASE   = 8'h10;

    localparam int FLAG_RD = 0;
    localparam int FLAG_WR = 1;
    localparam int FLAG_W  = 2;

endpackage

// File: rtl/j1_io_sat_counter.sv
// Saturating event counter; a clear takes priority over an increment.
module j1_io_sat_counter
    import j1_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [DATA_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/j1_io_fabric.sv
// J1 I/O page decoder, read mux and status page with access counters.
// Define IO_RDREG_EN to register io_din (one cycle of read latency).
module j1_io_fabric
    import j1_io_pkg::*;
#(
    parameter int          NUM_CH        = 4,
    parameter logic [63:0] CH_PAGES      = 64'h0000000070696867,
    parameter logic [7:0]  STAT_PAGE     = 8'h7F,
    parameter logic [15:0] DEFAULT_RDATA = 16'h0666
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_i,
    input  logic                     io_rd,
    input  logic                     io_wr,
    input  logic [15:0]              io_addr,
    input  logic [15:0]              io_dout,
    output logic [15:0]              io_din,
    output logic [NUM_CH-1:0]        ch_cs,
    input  logic [NUM_CH*16-1:0]     ch_rdata,
    output logic                     err_o
);

    logic [PAGE_W-1:0] page;
    logic [PAGE_W-1:0] off;
    logic              is_stat;
    logic              hit;
    logic              access;
    logic              unmapped;
    logic              stat_wr;
    logic [NUM_CH-1:0] cs;
    logic [DATA_W-1:0] ch_val;
    logic [DATA_W-1:0] acc_val;
    logic [DATA_W-1:0] stat_val;
    logic [DATA_W-1:0] mux_val;
    logic [DATA_W-1:0] unmap_cnt;
    logic [DATA_W-1:0] last_unmap;
    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] flags_nxt;
    logic [DATA_W-1:0] acc_cnt [NUM_CH];
    logic              unused_dout;

    assign page        = io_addr[15:8];
    assign off         = io_addr[7:0];
    assign unused_dout = ^io_dout[DATA_W-1:FLAG_W];

    // First matching channel wins, so duplicate pages still give one-hot selects.
    always_comb begin
        cs      = '0;
        hit     = 1'b0;
        ch_val  = '0;
        is_stat = (page == STAT_PAGE);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && !is_stat &&
                page == CH_PAGES[PAGE_W*i +: PAGE_W]) begin
                cs[i]  = 1'b1;
                hit    = 1'b1;
                ch_val = ch_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign ch_cs    = cs;
    assign access   = io_rd | io_wr;
    assign unmapped = access && !hit && !is_stat;
    assign stat_wr  = io_wr && is_stat;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_acc
        j1_io_sat_counter u_cnt (
            .clk   (sys_clk_i),
            .rst   (sys_rst_i),
            .clr   (stat_wr && off == STAT_ACC_BASE + PAGE_W'(i)),
            .inc   (access && cs[i]),
            .count (acc_cnt[i])
        );
    end

    j1_io_sat_counter u_unmap (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .clr   (stat_wr && off == STAT_UNMAP_CNT),
        .inc   (unmapped),
        .count (unmap_cnt)
    );

    always_comb begin
        flags_nxt = flags;
        if (stat_wr && off == STAT_FLAGS) begin
            flags_nxt = flags & ~io_dout[FLAG_W-1:0];
        end
        if (unmapped) begin
            if (io_rd) flags_nxt[FLAG_RD] = 1'b1;
            if (io_wr) flags_nxt[FLAG_WR] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            flags      <= '0;
            last_unmap <= '0;
            err_o      <= 1'b0;
        end else begin
            flags <= flags_nxt;
            err_o <= |flags_nxt;
            if (unmapped) last_unmap <= io_addr;
        end
    end

    always_comb begin
        acc_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == STAT_ACC_BASE + PAGE_W'(i)) acc_val = acc_cnt[i];
        end
        unique case (1'b1)
            (off == STAT_UNMAP_CNT):  stat_val = unmap_cnt;
            (off == STAT_LAST_UNMAP): stat_val = last_unmap;
            (off == STAT_FLAGS):      stat_val = {{(DATA_W-FLAG_W){1'b0}}, flags};
            default:                  stat_val = acc_val;
        endcase
    end

    always_comb begin
        unique case (1'b1)
            hit:     mux_val = ch_val;
            is_stat: mux_val = stat_val;
            default: mux_val = DEFAULT_RDATA;
        endcase
    end

`ifdef IO_RDREG_EN
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) io_din <= DEFAULT_RDATA;
        else           io_din <= mux_val;
    end
`else
    assign io_din = mux_val;
`endif

endmodule

// File: tb/tb_j1_io_fabric.sv
// Directed bench for j1_io_fabric with a read-data scoreboard.
// Honours IO_RDREG_EN for read latency.
module tb_j1_io_fabric;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [15:0] io_dout = '0;
    logic [15:0] io_din;
    logic [3:0]  ch_cs;
    logic [63:0] ch_rdata = '0;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    j1_io_fabric dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_din    (io_din),
        .ch_cs     (ch_cs),
        .ch_rdata  (ch_rdata),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=%h expected=none", io_din);
        end else begin
            chk(tag_q.pop_front(), io_din, exp_q.pop_front());
        end
    endtask

    task automatic access(logic rd, logic wr, logic [15:0] addr,
                          logic [15:0] data);
        io_rd   = rd;
        io_wr   = wr;
        io_addr = addr;
        io_dout = data;
        @(posedge clk);
        #1;
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic rd_chk(logic [15:0] addr, logic [15:0] exp,
                          logic [3:0] cs_exp, string tag);
        io_rd   = 1'b1;
        io_addr = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        chk({tag, "_cs"}, 16'(ch_cs), 16'(cs_exp));
`ifndef IO_RDREG_EN
        sb_check();
`endif
        @(posedge clk);
        #1;
`ifdef IO_RDREG_EN
        sb_check();
`endif
        io_rd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err", 16'(err_o), 16'h0000);
        chk("rst_cs", 16'(ch_cs), 16'h0000);
        chk("rst_din", io_din, 16'h0666);
        rst = 1'b0;
        rd_chk(16'h7F00, 16'h0000, 4'b0000, "rst_unmap_cnt");
        rd_chk(16'h7F02, 16'h0000, 4'b0000, "rst_flags");

        ch_rdata = 64'h4444_3333_2222_1111;
        rd_chk(16'h6700, 16'h1111, 4'b0001, "ch0");
        rd_chk(16'h6812, 16'h2222, 4'b0010, "ch1");
        rd_chk(16'h69FF, 16'h3333, 4'b0100, "ch2");
        rd_chk(16'h7001, 16'h4444, 4'b1000, "ch3");
        rd_chk(16'h7F10, 16'h0001, 4'b0000, "acc0_one");
        rd_chk(16'h7F13, 16'h0001, 4'b0000, "acc3_one");

        rd_chk(16'h5A34, 16'h0666, 4'b0000, "unmap_rd");
        chk("unmap_err", 16'(err_o), 16'h0001);
        rd_chk(16'h7F00, 16'h0001, 4'b0000, "unmap_cnt1");
        rd_chk(16'h7F01, 16'h5A34, 4'b0000, "last_unmap");
        rd_chk(16'h7F02, 16'h0001, 4'b0000, "flags_rd");

        access(1'b0, 1'b1, 16'h0000, 16'hBEEF);
        rd_chk(16'h7F02, 16'h0003, 4'b0000, "flags_rw");
        rd_chk(16'h7F00, 16'h0002, 4'b0000, "unmap_cnt2");
        access(1'b0, 1'b1, 16'h7F02, 16'h0001);
        rd_chk(16'h7F02, 16'h0002, 4'b0000, "w1c_bit0");
        chk("w1c_err_hi", 16'(err_o), 16'h0001);
        access(1'b0, 1'b1, 16'h7F02, 16'h0002);
        rd_chk(16'h7F02, 16'h0000, 4'b0000, "w1c_bit1");
        chk("w1c_err_lo", 16'(err_o), 16'h0000);
        access(1'b0, 1'b1, 16'h7F00, 16'h0000);
        rd_chk(16'h7F00, 16'h0000, 4'b0000, "unmap_clr");

        access(1'b1, 1'b1, 16'h1234, 16'h0000);
        rd_chk(16'h7F00, 16'h0001, 4'b0000, "both_cnt");
        rd_chk(16'h7F02, 16'h0003, 4'b0000, "both_flags");
        rd_chk(16'h7F01, 16'h1234, 4'b0000, "both_last");

        io_rd   = 1'b1;
        io_addr = 16'h6900;
        repeat (65540) @(posedge clk);
        #1;
        io_rd = 1'b0;
        rd_chk(16'h7F12, 16'hFFFF, 4'b0000, "acc2_sat");
        rd_chk(16'h7F10, 16'h0001, 4'b0000, "acc0_keep");
        rd_chk(16'h7F11, 16'h0001, 4'b0000, "acc1_keep");
        access(1'b0, 1'b1, 16'h7F12, 16'h0000);
        rd_chk(16'h7F12, 16'h0000, 4'b0000, "acc2_clr");
        rd_chk(16'h7F13, 16'h0001, 4'b0000, "acc3_keep");
        rd_chk(16'h7F05, 16'h0000, 4'b0000, "stat_other");

        rst = 1'b1;
        access(1'b1, 1'b0, 16'h5555, 16'h0000);
        rst = 1'b0;
        chk("rst2_err", 16'(err_o), 16'h0000);
        chk("rst2_din", io_din, 16'h0666);
        rd_chk(16'h7F00, 16'h0000, 4'b0000, "rst2_cnt");
        rd_chk(16'h7F01, 16'h0000, 4'b0000, "rst2_last");
        rd_chk(16'h7F02, 16'h0000, 4'b0000, "rst2_flags");
        rd_chk(16'h7F10, 16'h0000, 4'b0000, "rst2_acc0");
        rd_chk(16'h6700, 16'h1111, 4'b0001, "latency_ch0");
        chk("sb_empty", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/j1_io_fabric.md
Name: j1_io_fabric

Overview:
Parametrised I/O address decoder and read-data mux between the J1 CPU I/O port and NUM_CH memory-mapped peripherals.
- Decodes address bits [15:8] against a per-channel page table and drives one-hot chip-selects.
- Muxes peripheral read data back to the CPU.
- Adds an internal status page with per-channel access counters, unmapped-access capture, sticky error flags and an error output.
- Sits directly between the cpu0 instance and the peripheral instances in the SoC top.

Parameters:
- NUM_CH, 4, number of peripheral channels (1..8).
- CH_PAGES, 64'h0000000070696867, packed 8-bit page per channel; channel i uses bits [8i+7:8i].
- STAT_PAGE, 8'h7F, page of the fabric's own status registers; must not appear in CH_PAGES.
- DEFAULT_RDATA, 16'h0666, read data returned for unmapped addresses.

Ports:
- sys_clk_i  in  1  system clock; all state on rising edge.
- sys_rst_i  in  1  synchronous, active-high reset.
- io_rd  in  1  CPU read strobe.
- io_wr  in  1  CPU write strobe.
- io_addr  in  16  CPU I/O address.
- io_dout  in  16  CPU write data; used only for status-page writes.
- io_din  out  16  read data to CPU.
- ch_cs  out  NUM_CH  one-hot peripheral chip-selects.
- ch_rdata  in  NUM_CH*16  packed peripheral read data; channel i at [16i+15:16i].
- err_o  out  1  high while any sticky error flag is set.

Behaviour:
- Interface: one clock, sys_clk_i; reset sys_rst_i is synchronous and active-high.
- Reset values:
  - all counters 0, last_addr 0, flags 0, err_o 0.
  - ch_cs is combinational from io_addr and is unaffected by reset.
  - io_din = DEFAULT_RDATA in registered mode.
- Decode (combinational, every cycle, independent of rd/wr):
  - ch_cs[i] = 1 when io_addr[15:8] == page i.
  - Duplicate pages: lowest index wins, so ch_cs stays one-hot.
  - No match, or STAT_PAGE: ch_cs = 0.
- Read mux:
  - Channel hit: io_din = that channel's ch_rdata slice.
  - STAT_PAGE: io_din = status register selected by io_addr[7:0].
  - Otherwise: DEFAULT_RDATA.
- Status registers (addr[7:0]):
  - 0x00 UNMAP_CNT: 16-bit count of unmapped accesses; saturates at 0xFFFF.
  - 0x01 LAST_UNMAP: io_addr of the most recent unmapped access.
  - 0x02 FLAGS: bit0 = unmapped read seen, bit1 = unmapped write seen (sticky); bits 15:2 read 0.
  - 0x10+i ACC_CNT[i]: 16-bit count of accesses to channel i; saturates at 0xFFFF.
  - Any other status offset reads 0.
- Access event: (io_rd | io_wr) high in a cycle.
  - io_rd and io_wr both high counts as one access and sets both flag bits if unmapped.
  - Strobes are single-cycle from J1; a strobe held N cycles counts N accesses (documented, not filtered).
- Unmapped access (no channel hit, not STAT_PAGE), updated on the next clock edge:
  - UNMAP_CNT increments (saturating).
  - LAST_UNMAP <= io_addr.
  - Relevant flag bit(s) set.
- Channel access: ACC_CNT[i] increments (saturating); no other state changes.
- Status-page writes (io_wr at STAT_PAGE):
  - 0x00 clears UNMAP_CNT.
  - 0x02 clears the flag bits where io_dout bit = 1 (write-1-to-clear).
  - 0x10+i clears ACC_CNT[i].
  - Writes to other offsets are ignored.
  - Status-page accesses are never counted.
- err_o = |FLAGS, registered; it updates in the same edge as the flags.
- Reset mid-operation: all state is cleared at the edge; an access in the reset cycle is not recorded.

Optional Feature:
- IO_RDREG_EN defined:
  - io_din is registered, giving 1-cycle read latency.
  - The value is captured every cycle from the mux and shows status contents before that edge's update.
  - io_din resets to DEFAULT_RDATA.
- Undefined: io_din is purely combinational with zero latency, matching current J1 timing.

Decomposition:
- Package j1_io_pkg:
  - DATA_W=16, PAGE_W=8.
  - Status offsets STAT_UNMAP_CNT=8'h00, STAT_LAST_UNMAP=8'h01, STAT_FLAGS=8'h02, STAT_ACC_BASE=8'h10.
  - Flag bit indices.
- Sub-module j1_io_sat_counter: 16-bit saturating counter with synchronous clear and increment inputs; clear wins when both are high. It is instantiated NUM_CH+1 times.

Test Plan:
- Decode and mux:
  - Stimulus: set ch_rdata ch0..3 = 1111/2222/3333/4444; read 0x6700, 0x6812, 0x69FF, 0x7001.
  - Required: ch_cs = 0001/0010/0100/1000; io_din = 1111/2222/3333/4444.
- Unmapped read:
  - Stimulus: io_rd at 0x5A34.
  - Required: io_din = 0666, ch_cs = 0; next cycle UNMAP_CNT=1, LAST_UNMAP=5A34, FLAGS=0001, err_o=1.
- Write-1-to-clear:
  - Stimulus: unmapped write at 0x0000, so FLAGS=0003; then write 0x0001 to 0x7F02.
  - Required: FLAGS=0002, err_o=1; then write 0x0002, FLAGS=0000, err_o=0.
- Saturation:
  - Stimulus: force 65540 accesses to 0x6900.
  - Required: ACC_CNT[2]=FFFF; write to 0x7F12 gives 0000; other channel counters unchanged.
- Simultaneous strobes:
  - Stimulus: io_rd=io_wr=1 at 0x1234 for one cycle.
  - Required: UNMAP_CNT +1 only, FLAGS=0003.
- Reset and latency:
  - Stimulus: assert sys_rst_i during an unmapped access.
  - Required: all counters and flags 0, nothing recorded.
  - With IO_RDREG_EN: read of 0x6700 returns 1111 one cycle later.
